// File: rtl/csr_uart_pkg.sv
// Shared constants and state types for the CSR-mapped UART.
package csr_uart_pkg;

    localparam int STAT_RXEMPTY = 8;
    localparam int STAT_TXFULL  = 9;
    localparam int STAT_OVR     = 10;
    localparam int STAT_FERR    = 11;

    localparam int MOD_WRITE = 0;
    localparam int MOD_SET   = 1;
    localparam int MOD_CLEAR = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers carry one extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        // A full FIFO still takes a push when the same edge frees a slot.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/csr_uart_fifo.sv
// CSR-mapped 8N1 UART with TX/RX FIFOs; rdata is zero unless this block is selected.
// state | meaning (TX and RX): IDLE | line idle | START | start bit (RX: half-bit wait) | DATA | 8 bits LSB first | STOP | stop bit
module csr_uart_fifo
    import csr_uart_pkg::*;
#(
    parameter logic [11:0] CSR_ADDR   = 12'hBC4,
    parameter int          CLOCK_RATE = 200_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);

    tx_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        ovr_q, ovr_d, ferr_q, ferr_d;

    logic        sel, tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty, ferr_set;
    logic [7:0]  tx_head, rx_head;
    logic        unused_wdata;

    assign unused_wdata = ^{wdata[31:12], wdata[9:8]};

    assign sel     = (addr == CSR_ADDR);
    assign valid   = sel && (read || |modify);
    assign tx_push = sel && modify[MOD_WRITE];
    assign rx_pop  = sel && read;
    assign irq     = !rx_empty;
    assign tx      = tx_q;

    always_comb begin
        rdata = '0;
        if (valid) begin
            rdata[7:0]          = rx_head;
            rdata[STAT_RXEMPTY] = rx_empty;
            rdata[STAT_TXFULL]  = tx_full;
            rdata[STAT_OVR]     = ovr_q;
            rdata[STAT_FERR]    = ferr_q;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
        .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Leaving STOP straight into START keeps back-to-back frames gapless.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = BIT_RELOAD;
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_head;
                    tx_pop     = 1'b1;
                end
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = BIT_RELOAD;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = BIT_RELOAD;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_RELOAD;
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_head;
                    tx_pop     = 1'b1;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = HALF_RELOAD;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_RELOAD;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_RELOAD;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_RELOAD;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push  = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_sync_q;
        ferr_set = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && !rx_sync_q;
        ovr_d    = ovr_q;
        ferr_d   = ferr_q;
        if (sel && modify[MOD_CLEAR] && wdata[STAT_OVR])  ovr_d  = 1'b0;
        if (sel && modify[MOD_CLEAR] && wdata[STAT_FERR]) ferr_d = 1'b0;
        if (rx_push && rx_full && !(rx_pop && !rx_empty)) ovr_d = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
    end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Self-checking bench for csr_uart_fifo: DIV=10, FIFO_DEPTH=4, random bytes against a queue model.
module tb_csr_uart_fifo;
    localparam int          DIV   = 10;
    localparam int          DEPTH = 4;
    localparam logic [11:0] ADDR  = 12'hBC4;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        rx;
    logic        tx;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mon_q[$];
    int         mon_bad_stop = 0;
    bit         mon_en = 1'b0;

    logic [7:0] rx_model[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    csr_uart_fifo #(
        .CSR_ADDR(ADDR), .CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
        .rdata(rdata), .valid(valid), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    // Serial decoder on tx: samples mid-bit, collects every frame seen.
    initial begin : mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (DIV / 2 - 1) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge clk);
                    b[k] = tx;
                end
                repeat (DIV) @(negedge clk);
                if (tx !== 1'b1) mon_bad_stop++;
                mon_q.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left at 1ns after a rising edge; status sampled on the falling edge.
    task automatic csr_op(input logic [11:0] a, input logic rd, input logic [2:0] md,
                          input logic [31:0] wd, output logic [31:0] rdv, output logic vld);
        addr = a; read = rd; modify = md; wdata = wd;
        @(negedge clk);
        rdv = rdata;
        vld = valid;
        @(posedge clk);
        #1;
        read = 1'b0; modify = 3'b000; wdata = 32'h0; addr = 12'h0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_clks(DIV);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            wait_clks(DIV);
        end
        rx = stop;
        wait_clks(DIV);
        rx = 1'b1;
        wait_clks(DIV);
        if (!stop) m_ferr = 1'b1;
        else if (rx_model.size() < DEPTH) rx_model.push_back(b);
        else m_ovr = 1'b1;
    endtask

    function automatic logic [31:0] exp_status(input logic txf);
        logic [31:0] v;
        v = 32'h0;
        v[11] = m_ferr;
        v[10] = m_ovr;
        v[9]  = txf;
        v[8]  = (rx_model.size() == 0);
        if (rx_model.size() != 0) v[7:0] = rx_model[0];
        return v;
    endfunction

    task automatic model_pop();
        if (rx_model.size() != 0) void'(rx_model.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        mon_en = 1'b0;
        rst = 1'b1;
        wait_clks(3);
        n_cmp++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: tx=%b irq=%b, want tx=1 irq=0", tx, irq);
        end
        rst = 1'b0;
        wait_clks(2);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL reset_read: got %h, want 00000100", d);
        end
        csr_op(ADDR, 1'b0, 3'b001, 32'h5A, d, v);
        rx = 1'b0;
        wait_clks(15);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_tx: got %b, want 0 (bit0 of 5A)", tx);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tx=%b irq=%b, want tx=1 irq=0", tx, irq);
        end
        rx = 1'b1;
        @(posedge clk);
        #1;
        wait_clks(1);
        rst = 1'b0;
        rx_model.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        wait_clks(150);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_tx_idle: got %b, want 1", tx);
        end
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== 32'h0000_0100 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_rx_discarded: rdata=%h irq=%b, want 00000100 irq=0", d, irq);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic        v;
        logic [7:0]  byt;
        logic [9:0]  slot;
        logic        want;
        byt = 8'hA5;
        mon_q.delete();
        csr_op(ADDR, 1'b0, 3'b001, {24'h0, byt}, d, v);
        @(posedge clk);
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                slot[c] = tx;
            end
            want = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : byt[s-1];
            n_cmp++;
            if (slot !== {10{want}}) begin
                n_fail++;
                $display("FAIL tx_wave slot %0d: got %b, want %b", s, slot, {10{want}});
            end
        end
        @(posedge clk);
        #1;
        wait_clks(10);
        n_cmp++;
        if (mon_q.size() != 1 || mon_q[0] !== byt) begin
            n_fail++;
            $display("FAIL tx_frame: got %0d frames first=%h, want 1 frame a5", mon_q.size(),
                     (mon_q.size() != 0) ? mon_q[0] : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        logic [7:0]  b[3];
        mon_q.delete();
        for (int k = 0; k < 3; k++) b[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 3; k++) csr_op(ADDR, 1'b0, 3'b001, {24'h0, b[k]}, d, v);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 95 || i == 100 || i == 200) begin
                n_cmp++;
                if (tx !== (i == 95)) begin
                    n_fail++;
                    $display("FAIL b2b_gap at clk %0d: tx=%b, want %b", i, tx, (i == 95));
                end
            end
        end
        @(posedge clk);
        #1;
        wait_clks(120);
        n_cmp++;
        if (mon_q.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames, want 3", mon_q.size());
        end
        for (int k = 0; k < 3 && k < mon_q.size(); k++) begin
            n_cmp++;
            if (mon_q[k] !== b[k]) begin
                n_fail++;
                $display("FAIL b2b_byte %0d: got %h, want %h", k, mon_q[k], b[k]);
            end
        end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        logic        v;
        logic [7:0]  b[6];
        mon_q.delete();
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom_range(0, 255));
        csr_op(ADDR, 1'b0, 3'b001, {24'h0, b[0]}, d, v);
        wait_clks(3);
        for (int k = 1; k <= 5; k++) begin
            csr_op(ADDR, 1'b0, 3'b001, {24'h0, b[k]}, d, v);
            n_cmp++;
            if (d[9] !== 1'(k == 5)) begin
                n_fail++;
                $display("FAIL txfull_flag before write %0d: got %b, want %b", k, d[9], (k == 5));
            end
        end
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== 32'h0000_0300) begin
            n_fail++;
            $display("FAIL txfull_read: got %h, want 00000300", d);
        end
        wait_clks(650);
        n_cmp++;
        if (mon_q.size() != 5) begin
            n_fail++;
            $display("FAIL txfull_frames: got %0d frames, want 5", mon_q.size());
        end
        for (int k = 0; k < 5 && k < mon_q.size(); k++) begin
            n_cmp++;
            if (mon_q[k] !== b[k]) begin
                n_fail++;
                $display("FAIL txfull_byte %0d: got %h, want %h", k, mon_q[k], b[k]);
            end
        end
    endtask

    task automatic test_rx();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        rx_send(8'h3C, 1'b1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_irq_set: got %b, want 1", irq);
        end
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        model_pop();
        n_cmp++;
        if (d !== e || v !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_read_3c: rdata=%h valid=%b, want %h valid=1", d, v, e);
        end
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== e || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_read_empty: rdata=%h irq=%b, want %h irq=0", d, irq, e);
        end
        for (int k = 0; k < 3; k++) rx_send(8'($urandom_range(0, 255)), 1'b1);
        for (int k = 0; k < 4; k++) begin
            e = exp_status(1'b0);
            csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
            model_pop();
            n_cmp++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL rx_random read %0d: got %h, want %h", k, d, e);
            end
        end
    endtask

    task automatic test_overrun_ferr();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        for (int k = 0; k < 5; k++) rx_send(8'($urandom_range(0, 255)), 1'b1);
        for (int k = 0; k < 5; k++) begin
            e = exp_status(1'b0);
            csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
            model_pop();
            n_cmp++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL ovr_read %0d: got %h, want %h", k, d, e);
            end
        end
        rx_send(8'($urandom_range(0, 255)), 1'b0);
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL ferr_read: got %h, want %h", d, e);
        end
        csr_op(ADDR, 1'b0, 3'b010, 32'h0000_0C00, d, v);
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL csrrs_no_effect: got %h, want %h", d, e);
        end
        csr_op(ADDR, 1'b0, 3'b100, 32'h0000_0C00, d, v);
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL csrrc_clear: got %h, want %h", d, e);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        mon_q.delete();
        rx_send(8'($urandom_range(0, 255)), 1'b1);
        csr_op(12'hBC0, 1'b1, 3'b101, 32'h0000_0C00 | 32'($urandom_range(0, 255)), d, v);
        n_cmp++;
        if (v !== 1'b0 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL decode_other_addr: valid=%b rdata=%h, want valid=0 rdata=0", v, d);
        end
        wait_clks(20);
        n_cmp++;
        if (mon_q.size() != 0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_no_tx: frames=%0d tx=%b, want 0 frames tx=1", mon_q.size(), tx);
        end
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        model_pop();
        n_cmp++;
        if (d !== e) begin
            n_fail++;
            $display("FAIL decode_rx_kept: got %h, want %h", d, e);
        end
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(150);
        e = exp_status(1'b0);
        csr_op(ADDR, 1'b1, 3'b000, 32'h0, d, v);
        n_cmp++;
        if (d !== e || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_rejected: rdata=%h irq=%b, want %h irq=0", d, irq, e);
        end
        n_cmp++;
        if (mon_bad_stop != 0) begin
            n_fail++;
            $display("FAIL tx_stop_bits: got %0d bad stop bits, want 0", mon_bad_stop);
        end
    endtask

    initial begin
        rst = 1'b1;
        read = 1'b0;
        modify = 3'b000;
        wdata = 32'h0;
        addr = 12'h0;
        rx = 1'b1;
        #1;
        test_reset();
        test_tx();
        test_back_to_back();
        test_tx_full();
        test_rx();
        test_overrun_ferr();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
